// File: rtl/pattern_pkg.sv
// -----------------------------------------------------------------------------
// pattern_pkg
// Shared types and constants for the pattern tick controller and the
// downstream shift-register pattern stage.
//   mode_t      : animation mode encoding driven on pattern_tick_ctrl.mode
//   SPEED_*     : speed level limits and the level loaded at reset
//   KEY_*       : bit positions of the buttons inside key_raw
//   next_mode() : mode sequence ROT_L -> ROT_R -> KITT -> OFF -> ROT_L
// -----------------------------------------------------------------------------
package pattern_pkg;

    typedef enum logic [1:0] {
        MODE_ROT_L = 2'd0,
        MODE_ROT_R = 2'd1,
        MODE_KITT  = 2'd2,
        MODE_OFF   = 2'd3
    } mode_t;

    localparam logic [2:0] SPEED_MAX   = 3'd7;
    localparam logic [2:0] SPEED_MIN   = 3'd0;
    localparam logic [2:0] SPEED_RESET = 3'd4;

    localparam int KEY_NEXT  = 0;
    localparam int KEY_UP    = 1;
    localparam int KEY_DOWN  = 2;
    localparam int KEY_PAUSE = 3;

    function automatic mode_t next_mode(input mode_t cur);
        mode_t nxt;
        case (cur)
            MODE_ROT_L: nxt = MODE_ROT_R;
            MODE_ROT_R: nxt = MODE_KITT;
            MODE_KITT:  nxt = MODE_OFF;
            MODE_OFF:   nxt = MODE_ROT_L;
            default:    nxt = MODE_ROT_L;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One button: 2-flop synchroniser, debounce counter and press pulse.
//   clock   : system clock, rising edge
//   reset   : asynchronous active-high reset
//   key_raw : unsynchronised active-high button
//   press   : registered one-cycle pulse on a debounced 0->1 transition
// The stable value only follows the synchronised input after it has
// disagreed for 2^DEBOUNCE_W consecutive cycles; any agreement restarts
// the count. Releases are debounced the same way but produce no pulse.
// -----------------------------------------------------------------------------
module key_debounce
    import pattern_pkg::*;
#(
    parameter int DEBOUNCE_W = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic key_raw,
    output logic press
);

    localparam logic [DEBOUNCE_W-1:0] CNT_MAX = {DEBOUNCE_W{1'b1}};
    localparam logic [DEBOUNCE_W-1:0] CNT_ONE = {{(DEBOUNCE_W-1){1'b0}}, 1'b1};

    logic                  sync1_q;
    logic                  sync2_q;
    logic                  stable_q;
    logic                  stable_d;
    logic [DEBOUNCE_W-1:0] cnt_q;
    logic [DEBOUNCE_W-1:0] cnt_d;
    logic                  press_q;
    logic                  press_d;

    // Debounce counter, stable-value update and rising-edge detect.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else begin
                stable_d = stable_q;
                cnt_d    = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = '0;
        end
        // Pulse is registered alongside the stable flop so that the
        // controlled output moves exactly one edge later.
        press_d = stable_d & ~stable_q;
    end

    // Synchroniser, debounce state and press pulse registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            press_q  <= 1'b0;
        end else begin
            sync1_q  <= key_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            press_q  <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/pattern_tick_ctrl.sv
// -----------------------------------------------------------------------------
// pattern_tick_ctrl
// Button-driven controller for an LED pattern stage: debounces four keys,
// keeps animation mode, speed level and pause state, and produces the
// pattern-advance strobe from a power-of-two tick divider.
//   clock   : system clock, rising edge
//   reset   : asynchronous active-high reset (deassertion synchronised
//             outside this block)
//   key_raw : [0] next mode, [1] speed up, [2] speed down, [3] pause toggle
//   mode    : animation mode (pattern_pkg::mode_t encoding)
//   step_en : one-cycle advance strobe, high while divider == P-1
//   speed   : speed level 0 (slowest) .. 7 (fastest)
//   paused  : high while ticking is suspended
// Tick period P = 2^(BASE_DIV_W+7-speed) cycles.
// -----------------------------------------------------------------------------
module pattern_tick_ctrl
    import pattern_pkg::*;
#(
    parameter int DEBOUNCE_W = 16,
    parameter int BASE_DIV_W = 19
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] key_raw,
    output logic [1:0] mode,
    output logic       step_en,
    output logic [2:0] speed,
    output logic       paused
);

    // Wide enough for P-1 at the slowest speed.
    localparam int DIV_W = BASE_DIV_W + 7;
    localparam logic [DIV_W-1:0] DIV_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W:0]   P_ONE   = {{DIV_W{1'b0}}, 1'b1};

    // Terminal divider count P-1 for a speed level. At speed 0 the shifted
    // one falls off the top and the subtraction wraps to all ones.
    function automatic logic [DIV_W-1:0] period_m1(input logic [2:0] spd);
        logic [DIV_W:0] p;
        p = P_ONE << (DIV_W - int'(spd));
        return p[DIV_W-1:0] - DIV_ONE;
    endfunction

    logic [3:0]       press;

    mode_t            mode_q;
    mode_t            mode_d;
    logic [2:0]       speed_q;
    logic [2:0]       speed_d;
    logic             paused_q;
    logic             paused_d;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;
    logic             step_q;
    logic             step_d;
    logic             speed_chg;

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_key
        key_debounce #(
            .DEBOUNCE_W (DEBOUNCE_W)
        ) u_key_debounce (
            .clock   (clock),
            .reset   (reset),
            .key_raw (key_raw[gi]),
            .press   (press[gi])
        );
    end

    // Mode, speed and pause updates from press events.
    always_comb begin
        mode_d   = mode_q;
        speed_d  = speed_q;
        paused_d = paused_q;

        if (press[KEY_NEXT]) begin
            mode_d = next_mode(mode_q);
        end else begin
            mode_d = mode_q;
        end

        // Simultaneous up and down cancel.
        if (press[KEY_UP] && !press[KEY_DOWN]) begin
            if (speed_q != SPEED_MAX) begin
                speed_d = speed_q + 3'd1;
            end else begin
                speed_d = speed_q;
            end
        end else if (press[KEY_DOWN] && !press[KEY_UP]) begin
            if (speed_q != SPEED_MIN) begin
                speed_d = speed_q - 3'd1;
            end else begin
                speed_d = speed_q;
            end
        end else begin
            speed_d = speed_q;
        end

        paused_d = paused_q ^ press[KEY_PAUSE];
    end

    // Tick divider and advance strobe.
    always_comb begin
        speed_chg = (speed_d != speed_q);
        div_d     = div_q;

        // A speed change restarts the period; pause freezes the count
        // from the cycle after the pause event takes effect.
        if (speed_chg) begin
            div_d = '0;
        end else if (paused_q) begin
            div_d = div_q;
        end else if (div_q == period_m1(speed_q)) begin
            div_d = '0;
        end else begin
            div_d = div_q + DIV_ONE;
        end

        // Look ahead at the next divider value so the registered strobe
        // sits in the same cycle as divider == P-1.
        step_d = !speed_chg && !paused_d && (div_d == period_m1(speed_d));
    end

    // Control state and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mode_q   <= MODE_ROT_L;
            speed_q  <= SPEED_RESET;
            paused_q <= 1'b0;
            div_q    <= '0;
            step_q   <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            speed_q  <= speed_d;
            paused_q <= paused_d;
            div_q    <= div_d;
            step_q   <= step_d;
        end
    end

    assign mode    = mode_q;
    assign speed   = speed_q;
    assign paused  = paused_q;
    assign step_en = step_q;

endmodule
